// File: rtl/sr04_pkg.sv
// Shared types and constants for the SR04 distance-to-ASCII formatter.
package sr04_pkg;

  // Width of the distance measurement in cm.
  localparam int unsigned DataWidth = 14;

  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiC    = 8'h63;
  localparam logic [7:0] AsciiM    = 8'h6D;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StSend,
    StGuard
  } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per cycle, DataWidth steps after start.
module bin2bcd_seq
  import sr04_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DataWidth-1:0] bin,
  output logic [15:0]          bcd,
  output logic                 done
);

  localparam int unsigned SrWidth = 16 + DataWidth;

  // {bcd digits, remaining binary bits} shifted together.
  logic [SrWidth-1:0] sr_q;
  logic [15:0]        adj;
  logic [3:0]         cnt_q;
  logic               run_q;

  // Add 3 to every BCD digit of 5 or more before the shift.
  always_comb begin
    adj = sr_q[SrWidth-1:DataWidth];
    for (int i = 0; i < 4; i++) begin
      if (sr_q[DataWidth + 4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = sr_q[DataWidth + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Pulses during the final step; bcd holds the result from the next cycle on.
  assign done = run_q && (cnt_q == 4'(DataWidth - 1));
  assign bcd  = sr_q[SrWidth-1:DataWidth];

  // Load on start, then shift once per cycle until all bits are consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sr_q  <= {16'd0, bin};
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sr_q  <= {adj, sr_q[DataWidth-1:0]} << 1;
      cnt_q <= cnt_q + 4'd1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr04_ascii_fmt.sv
// Formats an SR04 distance in cm as an ASCII line: digits (no leading zeros), CR, LF.
// Optional macro SR04_UNIT_SUFFIX_EN inserts "cm" between the digits and CR.
module sr04_ascii_fmt
  import sr04_pkg::*;
#(
  parameter int unsigned MAX_CM = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [DataWidth-1:0] sr04_data,
  input  logic                 tx_busy,
  output logic                 go_ascii,
  output logic [7:0]           ascii,
  output logic                 busy
);

  localparam logic [DataWidth-1:0] MaxCm = DataWidth'(MAX_CM);
`ifdef SR04_UNIT_SUFFIX_EN
  localparam logic [2:0] LastPos = 3'd7;
`else
  localparam logic [2:0] LastPos = 3'd5;
`endif

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 go_q, go_d;
  logic [7:0]           ascii_q, ascii_d;
  logic [2:0]           ptr_q, ptr_d;

  logic [15:0]          bcd;
  logic                 bcd_done;
  logic [2:0]           first_pos;
  logic [2:0]           pos;
  logic [7:0]           cur_byte;
  logic [DataWidth-1:0] sat_data;

  assign sat_data = (sr04_data > MaxCm) ? MaxCm : sr04_data;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_q),
    .bin   (data_q),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // Frame starts at the first non-zero digit; the units digit is always sent.
  always_comb begin
    if (bcd[15:12] != 4'd0) begin
      first_pos = 3'd0;
    end else if (bcd[11:8] != 4'd0) begin
      first_pos = 3'd1;
    end else if (bcd[7:4] != 4'd0) begin
      first_pos = 3'd2;
    end else begin
      first_pos = 3'd3;
    end
  end

  assign pos = first_pos + ptr_q;

  // Byte at the current frame position: digits 0..3, optional suffix, CR, LF.
  always_comb begin
    cur_byte = AsciiLf;
    case (pos)
      3'd0:    cur_byte = AsciiZero + {4'd0, bcd[15:12]};
      3'd1:    cur_byte = AsciiZero + {4'd0, bcd[11:8]};
      3'd2:    cur_byte = AsciiZero + {4'd0, bcd[7:4]};
      3'd3:    cur_byte = AsciiZero + {4'd0, bcd[3:0]};
`ifdef SR04_UNIT_SUFFIX_EN
      3'd4:    cur_byte = AsciiC;
      3'd5:    cur_byte = AsciiM;
      3'd6:    cur_byte = AsciiCr;
`else
      3'd4:    cur_byte = AsciiCr;
`endif
      default: cur_byte = AsciiLf;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    go_d    = 1'b0;
    ascii_d = ascii_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          data_d  = sat_data;
          start_d = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = 3'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        if (bcd_done) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          go_d    = 1'b1;
          ascii_d = cur_byte;
          state_d = StGuard;
        end
      end
      StGuard: begin
        // tx_busy is deliberately ignored here.
        if (pos == LastPos) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          ptr_d   = ptr_q + 3'd1;
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      ascii_q <= 8'h00;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      ascii_q <= ascii_d;
      ptr_q   <= ptr_d;
    end
  end

  assign go_ascii = go_q;
  assign ascii    = ascii_q;
  assign busy     = busy_q;

endmodule

// File: doc/sr04_ascii_fmt.md
SR04_ASCII_FMT -- requirements
Module: sr04_ascii_fmt

Interface
REQ-001 Parameter: MAX_CM, 9999, saturation limit for displayed distance in cm (range 1..9999).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 data_valid  input  1  one-cycle pulse: sr04_data holds a new measurement.
REQ-005 sr04_data  input  14  distance in cm, unsigned binary, from the sr04 measurement stage.
REQ-006 tx_busy  input  1  downstream UART transmitter busy; high = cannot accept a byte.
REQ-007 go_ascii  output  1  one-cycle strobe: ascii is valid, the downstream stage transmits it.
REQ-008 ascii  output  8  character byte, stable in the go_ascii cycle.
REQ-009 busy  output  1  high from accepted data_valid until the last byte strobe.

Function
REQ-010 States SHALL be IDLE, CONV, SEND, GUARD; all outputs registered.
REQ-011 IDLE: data_valid=1 -> latch min(sr04_data, MAX_CM), busy=1, go to CONV next cycle.
REQ-012 CONV: sequential double-dabble, exactly 14 cycles, yields 4 BCD digits, then SEND.
REQ-013 Byte frame: decimal digits MSB-first with leading zeros suppressed (the units digit is always sent), then 8'h0D, 8'h0A.
REQ-014 Digit byte = 8'h30 + BCD digit.
REQ-015 SEND: tx_busy=0 -> go_ascii=1 for exactly one cycle with the current byte, then GUARD; tx_busy=1 -> hold, no strobe.
REQ-016 GUARD: exactly 1 cycle with tx_busy ignored, then SEND for the next byte, or IDLE with busy=0 after the LF byte.
REQ-017 Latency: with tx_busy held low, the first go_ascii SHALL be high 16 cycles after the data_valid sampling edge; consecutive strobes are 2 cycles apart.
REQ-018 data_valid while busy=1 SHALL be ignored; the frame in progress is unaffected and no request is queued.
REQ-019 data_valid arriving in the same cycle that busy falls SHALL be ignored; acceptance occurs only in IDLE.
REQ-020 sr04_data > MAX_CM (up to 16383) SHALL saturate to MAX_CM before conversion.
REQ-021 ascii SHALL hold its last value between strobes; go_ascii never high on consecutive cycles.

Reset
REQ-022 rst=1 SHALL force IDLE, go_ascii=0, ascii=8'h00, busy=0, BCD and latch registers to 0 on the next edge.
REQ-023 rst mid-CONV or mid-SEND SHALL abort the frame; no further bytes are emitted and no partial frame resumes.

Configuration
REQ-024 Macro SR04_UNIT_SUFFIX_EN: when defined, the frame SHALL insert 8'h63 ('c') and 8'h6D ('m') between the last digit and CR.
REQ-025 When SR04_UNIT_SUFFIX_EN is not defined, the frame SHALL be digits, CR, LF only, and no suffix logic is synthesised.

Structure
REQ-026 Package sr04_pkg SHALL hold the state enum, ASCII constants (ZERO 8'h30, CR 8'h0D, LF 8'h0A, C 8'h63, M 8'h6D), and the 14-bit data width.
REQ-027 Sub-module bin2bcd_seq SHALL implement the 14-cycle double-dabble, with start/done ports and a 16-bit BCD output.

Verification
REQ-028 sr04_data=123, tx_busy=0 -> go_ascii bytes 31,32,33,0D,0A; the first strobe 16 cycles after data_valid; busy falls after 0A.
REQ-029 sr04_data=0 -> bytes 30,0D,0A; sr04_data=1005 -> 31,30,30,35,0D,0A (internal zeros kept).
REQ-030 sr04_data=12000 -> saturates to 39,39,39,39,0D,0A.
REQ-031 tx_busy held high 50 cycles at SEND -> no strobe; tx_busy drops -> strobe on the next cycle; tx_busy pulsed high during GUARD has no effect.
REQ-032 Second data_valid during SEND -> ignored, exactly one frame; rst asserted after the 2nd byte -> go_ascii=0, busy=0 on the next edge, no further bytes.
REQ-033 With SR04_UNIT_SUFFIX_EN defined, sr04_data=57 -> 35,37,63,6D,0D,0A.
